// File: rtl/axis_decimator.sv
// AXI-Stream decimator: forwards the first beat of every group of N accepted
// input beats and discards the rest. A single output register holds the
// forwarded sample, with no skid buffer. Rates 0 and 1 both mean pass-through.
module axis_decimator #(
  parameter int unsigned BUS_WIDTH  = 2,
  parameter int unsigned RATE_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [RATE_WIDTH-1:0]   rate,
  input  logic [BUS_WIDTH*8-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [BUS_WIDTH*8-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int unsigned DATA_W = BUS_WIDTH * 8;

  logic [RATE_WIDTH-1:0] phase_q, phase_d;
  logic [RATE_WIDTH-1:0] n_q, n_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  run_q, run_d;

  logic [RATE_WIDTH-1:0] rate_norm;
  logic [RATE_WIDTH-1:0] n_eff;
  logic                  s_ready;
  logic                  accept;
  logic                  fwd;

  // Handshake decode: group length in force, ready, and which beat is forwarded
  always_comb begin
    rate_norm = (rate == '0) ? RATE_WIDTH'(1) : rate;
    // The beat at phase 0 opens a new group, so it uses the live rate input
    // (the value being latched now); later beats use the latched length.
    n_eff     = (phase_q == '0) ? rate_norm : n_q;
    // run_q holds ready low through reset without putting the async reset
    // net into combinational logic.
    s_ready   = run_q & ((phase_q != '0) | ~m_valid_q | m_axis_tready);
    accept    = s_axis_tvalid & s_ready;
    fwd       = accept & (phase_q == '0);
  end

  // Next-state: phase counter, group length latch and output register
  always_comb begin
    run_d    = 1'b1;
    phase_d  = phase_q;
    n_d      = n_q;
    m_data_d = m_data_q;
    m_valid_d = m_valid_q;

    if (accept) begin
      if (phase_q == n_eff - RATE_WIDTH'(1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + RATE_WIDTH'(1);
      end
    end

    if (fwd) begin
      n_d       = rate_norm;
      m_data_d  = s_axis_tdata;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      run_q     <= 1'b0;
      phase_q   <= '0;
      n_q       <= RATE_WIDTH'(1);
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      phase_q   <= phase_d;
      n_q       <= n_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;

endmodule

// File: tb/tb_axis_decimator.sv
// Directed bench for axis_decimator: decimation at several rates, backpressure,
// mid-group rate change, reset mid-group and a throttled long run.
module tb_axis_decimator;

  localparam int unsigned BW = 2;
  localparam int unsigned RW = 8;
  localparam int unsigned DW = BW * 8;

  logic          aclk = 1'b0;
  logic          arstn;
  logic [RW-1:0] rate;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] exp_q[$];
  bit            rand_ready = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int unsigned   cyc;

  axis_decimator #(.BUS_WIDTH(BW), .RATE_WIDTH(RW)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .rate          (rate),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready)
  );

  // 100 MHz clock
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: logs every transfer and checks data holds while stalled
  always @(negedge aclk) begin
    if (!arstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) out_q.push_back(m_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Random downstream backpressure when enabled
  always @(posedge aclk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Presents one beat and waits for it to be accepted (called at posedge+1)
  task automatic drive_beat(input logic [DW-1:0] d, output int unsigned cycles);
    logic ok;
    s_data  = d;
    s_valid = 1'b1;
    cycles  = 0;
    do begin
      @(negedge aclk);
      ok = s_ready;
      @(posedge aclk);
      #1;
      cycles++;
    end while (!ok && cycles < 200);
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int unsigned n);
    s_valid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    #1 arstn = 1'b0;
    @(posedge aclk);
    #1 arstn = 1'b1;
    idle(2);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check(tag, 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arstn   = 1'b0;
    rate    = 8'd1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    // Reset values, before and after a clock edge under reset
    #3;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge aclk);
    #1;
    check("rst_edge_m_valid", 32'(m_valid), 32'd0);
    check("rst_edge_s_ready", 32'(s_ready), 32'd0);
    arstn = 1'b1;
    idle(2);

    // Rate 4, continuous input 0..15
    rate = 8'd4;
    out_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive_beat(DW'(i), cyc);
      check("r4_cycles", cyc, 32'd1);
      if (i % 4 == 0) begin
        check("r4_lat_valid", 32'(m_valid), 32'd1);
        check("r4_lat_data", 32'(m_data), 32'(i));
      end else if (i % 4 == 1) begin
        check("r4_drop_valid", 32'(m_valid), 32'd0);
      end
    end
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i * 4));
    check_outputs("r4_out");

    // Rate 0 then rate 1: pass-through at one beat per cycle
    apply_reset();
    out_q.delete();
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      rate = RW'(r);
      for (int i = 0; i < 8; i++) begin
        drive_beat(DW'(16'h0010 + i), cyc);
        check("pass_cycles", cyc, 32'd1);
        check("pass_data", 32'(m_data), 32'(16'h0010 + i));
        exp_q.push_back(DW'(16'h0010 + i));
      end
    end
    idle(3);
    check_outputs("pass_out");

    // Rate 3 with downstream stalled after the first output
    apply_reset();
    out_q.delete();
    rate    = 8'd3;
    m_ready = 1'b0;
    drive_beat(DW'(0), cyc);
    check("bp_first_valid", 32'(m_valid), 32'd1);
    check("bp_first_data", 32'(m_data), 32'd0);
    drive_beat(DW'(1), cyc);
    check("bp_beat1_cycles", cyc, 32'd1);
    drive_beat(DW'(2), cyc);
    check("bp_beat2_cycles", cyc, 32'd1);
    s_data  = DW'(3);
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("bp_beat3_ready", 32'(s_ready), 32'd0);
      check("bp_hold_data", 32'(m_data), 32'd0);
    end
    @(posedge aclk);
    #1;
    m_ready = 1'b1;
    drive_beat(DW'(3), cyc);
    check("bp_release_cycles", cyc, 32'd1);
    check("bp_new_data", 32'(m_data), 32'd3);
    idle(3);
    exp_q.delete();
    exp_q.push_back(DW'(0));
    exp_q.push_back(DW'(3));
    check_outputs("bp_out");

    // Rate 2 for the first group, 5 presented from its second beat on
    apply_reset();
    out_q.delete();
    for (int i = 0; i < 15; i++) begin
      rate = (i == 0) ? 8'd2 : 8'd5;
      drive_beat(DW'(i), cyc);
    end
    idle(3);
    exp_q.delete();
    exp_q.push_back(DW'(0));
    exp_q.push_back(DW'(2));
    exp_q.push_back(DW'(7));
    exp_q.push_back(DW'(12));
    check_outputs("rchg_out");

    // Reset mid-group with an output pending
    apply_reset();
    out_q.delete();
    rate    = 8'd4;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(DW'(i), cyc);
    check("mrst_pending", 32'(m_valid), 32'd1);
    #1 arstn = 1'b0;
    #1;
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_m_data", 32'(m_data), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge aclk);
    #1 arstn = 1'b1;
    m_ready = 1'b1;
    idle(2);
    check("mrst_no_output", 32'(m_valid), 32'd0);
    drive_beat(DW'(16'h00AA), cyc);
    check("mrst_new_valid", 32'(m_valid), 32'd1);
    check("mrst_new_data", 32'(m_data), 32'h00AA);
    idle(3);
    exp_q.delete();
    exp_q.push_back(DW'(16'h00AA));
    check_outputs("mrst_out");

    // Rate 7, 700 beats with random input gaps and output backpressure
    apply_reset();
    out_q.delete();
    rate       = 8'd7;
    rand_ready = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drive_beat(DW'(i), cyc);
    end
    s_valid    = 1'b0;
    rand_ready = 1'b0;
    @(posedge aclk);
    #1;
    m_ready = 1'b1;
    idle(6);
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(DW'(i * 7));
    check_outputs("rand_out");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
